// File: rtl/otter_hazard_ctrl_if.sv
// Bundle of pipeline hazard signals between the OTTER datapath and the
// hazard/sequencing controller. The datapath side (master) drives register
// addresses and stage status; the controller side (slave) returns forward
// selects, pipeline enables, flush controls and status counters.
interface otter_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       DE_RS1;
    logic [4:0]       DE_RS2;
    logic             DE_USES_RS1;
    logic             DE_USES_RS2;
    logic [4:0]       EX_RD;
    logic             EX_RW;
    logic             EX_IS_LOAD;
    logic [4:0]       MEM_RD;
    logic             MEM_RW;
    logic             BR_TAKEN;
    logic             DMEM_BUSY;
    logic [1:0]       FWD_A;
    logic [1:0]       FWD_B;
    logic             PC_WE;
    logic             IF_DE_WE;
    logic             DE_EX_WE;
    logic             EX_MEM_WE;
    logic             DE_EX_BUBBLE;
    logic             FLUSH_IF;
    logic             FLUSH_DE;
    logic             MEM_ERR;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;

    modport master (
        output DE_RS1, DE_RS2, DE_USES_RS1, DE_USES_RS2,
        output EX_RD, EX_RW, EX_IS_LOAD, MEM_RD, MEM_RW,
        output BR_TAKEN, DMEM_BUSY,
        input  FWD_A, FWD_B, PC_WE, IF_DE_WE, DE_EX_WE, EX_MEM_WE,
        input  DE_EX_BUBBLE, FLUSH_IF, FLUSH_DE, MEM_ERR, STALL_CNT, FLUSH_CNT
    );

    modport slave (
        input  DE_RS1, DE_RS2, DE_USES_RS1, DE_USES_RS2,
        input  EX_RD, EX_RW, EX_IS_LOAD, MEM_RD, MEM_RW,
        input  BR_TAKEN, DMEM_BUSY,
        output FWD_A, FWD_B, PC_WE, IF_DE_WE, DE_EX_WE, EX_MEM_WE,
        output DE_EX_BUBBLE, FLUSH_IF, FLUSH_DE, MEM_ERR, STALL_CNT, FLUSH_CNT
    );
endinterface

// File: rtl/otter_hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage OTTER core.
// Produces ALU operand forward selects, pipeline register write enables,
// bubble/flush controls for load-use stalls, data-memory waits and redirects,
// a sticky memory-timeout flag and saturating stall/redirect counters.
// Control outputs are Mealy: they depend on the current state and inputs and
// act at the very next rising edge.
module otter_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    otter_hazard_ctrl_if.slave    hz
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               lu_s;
    logic               run_rules_s;
    logic               pc_we_s, if_de_we_s, de_ex_we_s, ex_mem_we_s;
    logic               bubble_s, flush_if_s, flush_de_s;
    logic [1:0]         fwd_a_s, fwd_b_s;

    // Forward select for one source register: EX result beats MEM result;
    // a load in EX cannot forward because its data is not yet available.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] ex_rd,
        input logic       ex_rw,
        input logic       ex_ld,
        input logic [4:0] mem_rd,
        input logic       mem_rw
    );
        logic [1:0] sel;
        if (ex_rw && (ex_rd != 5'd0) && (ex_rd == rs) && !ex_ld) begin
            sel = 2'b01;
        end else if (mem_rw && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        logic [CNT_W-1:0] r;
        if (en && (v != {CNT_W{1'b1}})) begin
            r = v + CNT_W'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand forwarding and load-use detection, independent of FSM state.
    always_comb begin
        fwd_a_s = fwd_sel(hz.DE_RS1, hz.EX_RD, hz.EX_RW, hz.EX_IS_LOAD, hz.MEM_RD, hz.MEM_RW);
        fwd_b_s = fwd_sel(hz.DE_RS2, hz.EX_RD, hz.EX_RW, hz.EX_IS_LOAD, hz.MEM_RD, hz.MEM_RW);
        lu_s    = hz.EX_IS_LOAD && hz.EX_RW && (hz.EX_RD != 5'd0) &&
                  ((hz.DE_USES_RS1 && (hz.EX_RD == hz.DE_RS1)) ||
                   (hz.DE_USES_RS2 && (hz.EX_RD == hz.DE_RS2)));
    end

    // Next-state logic and Mealy pipeline controls.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        run_rules_s = 1'b0;
        pc_we_s     = 1'b1;
        if_de_we_s  = 1'b1;
        de_ex_we_s  = 1'b1;
        ex_mem_we_s = 1'b1;
        bubble_s    = 1'b0;
        flush_if_s  = 1'b0;
        flush_de_s  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hz.DMEM_BUSY) begin
                    pc_we_s     = 1'b0;
                    if_de_we_s  = 1'b0;
                    de_ex_we_s  = 1'b0;
                    ex_mem_we_s = 1'b0;
                    wait_cnt_d  = WAIT_W'(1);
                    state_d     = ST_MEM_WAIT;
                end else begin
                    run_rules_s = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!hz.DMEM_BUSY) begin
                    // Memory released: the held branch/LU acts this cycle.
                    run_rules_s = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = ST_RUN;
                end else begin
                    pc_we_s     = 1'b0;
                    if_de_we_s  = 1'b0;
                    de_ex_we_s  = 1'b0;
                    ex_mem_we_s = 1'b0;
                    if (wait_cnt_q >= MAX_WAIT_C) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            ST_ERR: begin
                // Memory is considered dead: keep the pipeline moving.
                run_rules_s = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (run_rules_s) begin
            if (hz.BR_TAKEN) begin
                // Redirect squashes the DE instruction, so any LU is moot.
                flush_if_s = 1'b1;
                flush_de_s = 1'b1;
            end else if (lu_s) begin
                pc_we_s    = 1'b0;
                if_de_we_s = 1'b0;
                bubble_s   = 1'b1;
            end else begin
                bubble_s   = 1'b0;
            end
        end else begin
            flush_if_s = 1'b0;
        end

        if (RST) begin
            // Let every pipeline register load its cleared value.
            pc_we_s     = 1'b1;
            if_de_we_s  = 1'b1;
            de_ex_we_s  = 1'b1;
            ex_mem_we_s = 1'b1;
            bubble_s    = 1'b0;
            flush_if_s  = 1'b0;
            flush_de_s  = 1'b0;
        end else begin
            state_d = state_d;
        end

        stall_cnt_d = sat_inc(stall_cnt_q, !pc_we_s);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_if_s);
    end

    // State, sticky error and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.FWD_A        = fwd_a_s;
    assign hz.FWD_B        = fwd_b_s;
    assign hz.PC_WE        = pc_we_s;
    assign hz.IF_DE_WE     = if_de_we_s;
    assign hz.DE_EX_WE     = de_ex_we_s;
    assign hz.EX_MEM_WE    = ex_mem_we_s;
    assign hz.DE_EX_BUBBLE = bubble_s;
    assign hz.FLUSH_IF     = flush_if_s;
    assign hz.FLUSH_DE     = flush_de_s;
    assign hz.MEM_ERR      = mem_err_q;
    assign hz.STALL_CNT    = stall_cnt_q;
    assign hz.FLUSH_CNT    = flush_cnt_q;

endmodule
